yuv444to422: RTL
================

YUV444TO422 -- requirements
Module: yuv444to422

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, giving the width of each Y/U/V/C sample.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port resetb, input, 1, asynchronous reset, active-high (asserted = 1); one clock, reset asynchronous and active-high.
REQ-004 SHALL have port enable, input, 1; 1 = subsample and offset, 0 = bypass.
REQ-005 SHALL have port dvi, input, 1, input data valid.
REQ-006 SHALL have port dtypei, input, `DTYPE_WIDTH, input data type per dtypes.v.
REQ-007 SHALL have port yi, input, PIXEL_WIDTH, unsigned luma.
REQ-008 SHALL have port ui, input, PIXEL_WIDTH, signed two's-complement Cb without offset.
REQ-009 SHALL have port vi, input, PIXEL_WIDTH, signed two's-complement Cr without offset.
REQ-010 SHALL have port meta_datai, input, 16, sideband metadata.
REQ-011 SHALL have port dvo, output, 1, output data valid (registered).
REQ-012 SHALL have port dtypeo, output, `DTYPE_WIDTH, output data type (registered).
REQ-013 SHALL have port yo, output, PIXEL_WIDTH, luma out (registered).
REQ-014 SHALL have port co, output, PIXEL_WIDTH, interleaved chroma out, unsigned with offset (registered).
REQ-015 SHALL have port meta_datao, output, 16, metadata out (registered).

Function
REQ-016 SHALL have a fixed latency of 2 clocks from every input cycle to its output cycle; dvi, dtypei and meta_datai are delayed by exactly 2 clocks regardless of dtype or enable.
REQ-017 SHALL pass yi to yo unmodified in all modes; no luma offset is added.
REQ-018 SHALL keep a phase bit (EVEN/ODD), cleared to EVEN on reset and on any cycle with dvi=1 and a non-pixel dtype; it toggles on each cycle with dvi=1 and dtype `DTYPE_PIXEL.
REQ-019 Upstream guarantees that an ODD pixel follows its EVEN partner on the very next cycle; the block SHALL pair only on that adjacency.
REQ-020 Averaging SHALL sign-extend both operands to PIXEL_WIDTH+1, add them, add 1, then arithmetic-shift right by 1; the result fits PIXEL_WIDTH signed with no clamp.
REQ-021 Offset SHALL be adding 2^(PIXEL_WIDTH-1) modulo 2^PIXEL_WIDTH, which is equivalent to inverting the MSB.
REQ-022 EVEN pixel with a partner present (enable=1): co = offset(avg(U_even, U_odd)), and the block SHALL store offset(avg(V_even, V_odd)) in a Cr hold register.
REQ-023 ODD pixel (enable=1): co = the Cr hold register value.
REQ-024 Orphan EVEN pixel (next cycle is not a pixel with dvi=1, e.g. odd-length row) (enable=1): co = offset(U_even), Cr hold = offset(V_even), and phase returns to EVEN.
REQ-025 Non-pixel dtype or dvi=0: yo = yi and co = ui, passed raw with the 2-clock delay.
REQ-026 enable=0: co = ui raw for every cycle, with no averaging and no offset; the phase logic still runs.
REQ-027 enable SHALL be sampled alongside the data in the first stage so that a change mid-pair affects whole output cycles only.

Reset
REQ-028 While resetb=1, SHALL hold dvo, dtypeo, yo, co and meta_datao at 0, the pipeline stages and Cr hold at 0, and phase at EVEN.
REQ-029 Reset mid-row SHALL discard any pending EVEN pixel; the first pixel after release SHALL be EVEN.

Verification (PIXEL_WIDTH=8)
REQ-030 Pair stimulus: cycle n sends pixel Y=10, U=20, V=-10; cycle n+1 sends Y=30, U=41, V=-20. Required response: n+2 gives dvo=1, yo=10, co=159; n+3 gives yo=30, co=113.
REQ-031 Extremes stimulus: U pair of 127 and 127. Required response: co=255. Stimulus: U pair of -128 and -128. Required response: co=0. V pair of 127 and -128 gives Cr co=128.
REQ-032 Odd-length row stimulus: ROW_START followed by 3 pixels, the third with U=-5. Required response: the third output has co=123, and the next row's first pixel is treated as EVEN.
REQ-033 enable=0 stimulus: the pair from REQ-030. Required response: co=20 then co=41, yo=10 then 30, with latency 2.
REQ-034 Reset stimulus: assert resetb right after an EVEN pixel, then release and send the REQ-030 pair. Required response: outputs read 0 during reset, and REQ-030 values follow after release.
REQ-035 Metadata and dtype stimulus: meta_datai=0xBEEF on a FRAME_START cycle. Required response: two clocks later dvo=1, dtypeo=FRAME_START, meta_datao=0xBEEF, co=ui raw.

Source files
------------

// File: rtl/yuv444to422.sv
// 4:4:4 -> 4:2:2 chroma subsampler: pairs adjacent EVEN/ODD pixels, averages Cb/Cr,
// adds the unsigned chroma offset and emits interleaved Cb/Cr on co with a fixed 2-clock latency.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH       4
`define DTYPE_PIXEL       4'h0
`define DTYPE_FRAME_START 4'h1
`define DTYPE_FRAME_END   4'h2
`define DTYPE_ROW_START   4'h3
`define DTYPE_ROW_END     4'h4
`endif

module yuv444to422 #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [PIXEL_WIDTH-1:0]  yi,
  input  logic [PIXEL_WIDTH-1:0]  ui,
  input  logic [PIXEL_WIDTH-1:0]  vi,
  input  logic [15:0]             meta_datai,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0]  yo,
  output logic [PIXEL_WIDTH-1:0]  co,
  output logic [15:0]             meta_datao
);
  localparam int W = PIXEL_WIDTH;

  logic                    phase;
  logic                    s1_dv, s1_en, s1_odd;
  logic [`DTYPE_WIDTH-1:0] s1_dtype;
  logic [W-1:0]            s1_y, s1_u, s1_v;
  logic [15:0]             s1_meta;
  logic [W-1:0]            cr_hold, cr_next, co_next;
  logic                    in_pix, s1_pix;

  // (a + b + 1) >>> 1 in W+1 bits, then the offset, which is just an MSB flip
  function automatic logic [W-1:0] avg_off(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b} + {{W{1'b0}}, 1'b1};
    return {~s[W], s[W-1:1]};
  endfunction

  function automatic logic [W-1:0] off(input logic [W-1:0] a);
    return {~a[W-1], a[W-2:0]};
  endfunction

  assign in_pix = dvi && (dtypei == `DTYPE_PIXEL);
  assign s1_pix = s1_dv && (s1_dtype == `DTYPE_PIXEL);

  // Stage 1: capture the input beside the phase it arrived with. Any cycle that is not
  // a valid pixel sends phase back to EVEN, which also closes an orphan EVEN.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      phase    <= 1'b0;
      s1_dv    <= 1'b0;
      s1_en    <= 1'b0;
      s1_odd   <= 1'b0;
      s1_dtype <= '0;
      s1_y     <= '0;
      s1_u     <= '0;
      s1_v     <= '0;
      s1_meta  <= '0;
    end else begin
      phase    <= in_pix & ~phase;
      s1_dv    <= dvi;
      s1_en    <= enable;
      s1_odd   <= phase;
      s1_dtype <= dtypei;
      s1_y     <= yi;
      s1_u     <= ui;
      s1_v     <= vi;
      s1_meta  <= meta_datai;
    end
  end

  // An EVEN pixel in stage 1 sees its ODD partner on the live input, so the pair is
  // resolved one cycle before the ODD reaches stage 1 and reads cr_hold.
  always_comb begin
    co_next = s1_u;
    cr_next = cr_hold;
    if (s1_pix && s1_en) begin
      if (s1_odd) begin
        co_next = cr_hold;
      end else if (in_pix) begin
        co_next = avg_off(s1_u, ui);
        cr_next = avg_off(s1_v, vi);
      end else begin
        co_next = off(s1_u);
        cr_next = off(s1_v);
      end
    end
  end

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      cr_hold    <= '0;
      dvo        <= 1'b0;
      dtypeo     <= '0;
      yo         <= '0;
      co         <= '0;
      meta_datao <= '0;
    end else begin
      cr_hold    <= cr_next;
      dvo        <= s1_dv;
      dtypeo     <= s1_dtype;
      yo         <= s1_y;
      co         <= co_next;
      meta_datao <= s1_meta;
    end
  end
endmodule
